// File: rtl/e203_subsys_pllctrl_if.sv
// Configuration request bus for the PLL controller: valid/ready handshake
// carrying the divider settings, plus a one-cycle reject pulse back.
interface e203_subsys_pllctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_od;
  logic [7:0] cfg_m;
  logic [4:0] cfg_n;
  logic       cfg_err;

  modport master (
    output cfg_valid, cfg_od, cfg_m, cfg_n,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_od, cfg_m, cfg_n,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/e203_subsys_pllctrl.sv
// PLL sequencer: holds the PLL in reset, waits for lock, then switches the
// clock mux to the PLL output; handles reconfiguration and sleep/relock.
module e203_subsys_pllctrl #(
  parameter int unsigned RST_CYC  = 4,
  parameter int unsigned LOCK_CYC = 1024,
  parameter logic [1:0]  DEF_OD   = 2'd0,
  parameter logic [7:0]  DEF_M    = 8'd1,
  parameter logic [4:0]  DEF_N    = 5'd1
) (
  input  logic                       clk,
  input  logic                       rst,
  e203_subsys_pllctrl_if.slave       cfg,
  input  logic                       sleep_req,
  output logic                       pll_RESET,
  output logic                       pll_asleep,
  output logic [1:0]                 pll_OD,
  output logic [7:0]                 pll_M,
  output logic [4:0]                 pll_N,
  output logic                       pll_sel,
  output logic                       pll_locked
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    BYPASS = 3'd0,
    PRST   = 3'd1,
    LOCK   = 3'd2,
    RUN    = 3'd3,
    SLEEP  = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Per-state output word: {pll_RESET, pll_asleep, pll_sel, pll_locked, cfg_ready}
  function automatic logic [4:0] st_out(input state_t s);
    case (s)
      BYPASS:  st_out = 5'b10001;
      PRST:    st_out = 5'b10000;
      LOCK:    st_out = 5'b00000;
      RUN:     st_out = 5'b00111;
      SLEEP:   st_out = 5'b11000;
      default: st_out = 5'b10001;
    endcase
  endfunction

  // Outputs are loaded together with the state they belong to, so they are
  // registered and change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BYPASS;
      cnt    <= '0;
      pll_OD <= DEF_OD;
      pll_M  <= DEF_M;
      pll_N  <= DEF_N;
      cfg.cfg_err <= 1'b0;
      {pll_RESET, pll_asleep, pll_sel, pll_locked, cfg.cfg_ready} <= st_out(BYPASS);
    end else begin
      cfg.cfg_err <= 1'b0;
      case (state)
        BYPASS, RUN: begin
          // cfg_ready is high here, so cfg_valid alone completes a handshake;
          // a pending config takes priority over sleep.
          if (cfg.cfg_valid) begin
            if ((cfg.cfg_m != 8'd0) && (cfg.cfg_n != 5'd0)) begin
              pll_OD <= cfg.cfg_od;
              pll_M  <= cfg.cfg_m;
              pll_N  <= cfg.cfg_n;
              cnt    <= CNT_W'(RST_CYC - 1);
              state  <= PRST;
              {pll_RESET, pll_asleep, pll_sel, pll_locked, cfg.cfg_ready} <= st_out(PRST);
            end else begin
              cfg.cfg_err <= 1'b1;
            end
          end else if ((state == RUN) && sleep_req) begin
            state <= SLEEP;
            {pll_RESET, pll_asleep, pll_sel, pll_locked, cfg.cfg_ready} <= st_out(SLEEP);
          end
        end
        PRST: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(LOCK_CYC - 1);
            state <= LOCK;
            {pll_RESET, pll_asleep, pll_sel, pll_locked, cfg.cfg_ready} <= st_out(LOCK);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LOCK: begin
          if (cnt == '0) begin
            state <= RUN;
            {pll_RESET, pll_asleep, pll_sel, pll_locked, cfg.cfg_ready} <= st_out(RUN);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SLEEP: begin
          // Waking always performs a full relock with the held settings.
          if (!sleep_req) begin
            cnt   <= CNT_W'(RST_CYC - 1);
            state <= PRST;
            {pll_RESET, pll_asleep, pll_sel, pll_locked, cfg.cfg_ready} <= st_out(PRST);
          end
        end
        default: begin
          state <= BYPASS;
          cnt   <= '0;
          {pll_RESET, pll_asleep, pll_sel, pll_locked, cfg.cfg_ready} <= st_out(BYPASS);
        end
      endcase
    end
  end

endmodule

// File: doc/e203_subsys_pllctrl.md
E203_SUBSYS_PLLCTRL -- requirements
Module: e203_subsys_pllctrl

Interface
REQ-001 The parameter list SHALL be: RST_CYC, default 4, number of cycles pll_RESET is held per sequence (1..65535).
REQ-002 The parameter list SHALL include: LOCK_CYC, default 1024, lock-wait cycles after pll_RESET release (1..65535).
REQ-003 The parameter list SHALL include: DEF_OD/DEF_M/DEF_N, defaults 2'd0/8'd1/5'd1, configuration loaded at reset.
REQ-004 Port clk, input, 1 bit: the single block clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port cfg_valid, input, 1 bit: configuration request.
REQ-007 Port cfg_ready, output, 1 bit: configuration request accepted this cycle when both it and cfg_valid are high.
REQ-008 Port cfg_od/cfg_m/cfg_n, input, 2/8/5 bits: requested PLL divider settings.
REQ-009 Port cfg_err, output, 1 bit: one-cycle pulse flagging a rejected configuration.
REQ-010 Port sleep_req, input, 1 bit: level request to power down the PLL.
REQ-011 Ports pll_RESET, pll_asleep, output, 1 bit each: drive the PLL's reset and asleep inputs.
REQ-012 Ports pll_OD/pll_M/pll_N, output, 2/8/5 bits: drive the PLL's divider inputs.
REQ-013 Port pll_sel, output, 1 bit: clock-mux select, where 1 selects plloutclk and 0 selects pllrefclk.
REQ-014 Port pll_locked, output, 1 bit: set when the PLL is in RUN.

Function
REQ-015 The FSM SHALL have the states BYPASS, PRST, LOCK, RUN and SLEEP; all outputs SHALL be registered.
REQ-016 Per-state outputs SHALL be as follows (pll_RESET/pll_asleep/pll_sel/pll_locked/cfg_ready):
- BYPASS: 1/0/0/0/1
- PRST: 1/0/0/0/0
- LOCK: 0/0/0/0/0
- RUN: 0/0/1/1/1
- SLEEP: 1/1/0/0/0
REQ-017 A handshake in BYPASS or RUN with cfg_m!=0 and cfg_n!=0 SHALL latch cfg_od/m/n into pll_OD/M/N on the next cycle and enter PRST on the same edge.
REQ-018 A handshake with cfg_m==0 or cfg_n==0 SHALL complete the handshake, leave the state and pll_OD/M/N unchanged, and pulse cfg_err high for exactly one cycle on the next cycle.
REQ-019 PRST SHALL load the 16-bit down-counter with RST_CYC-1 on entry and stay for exactly RST_CYC cycles, then enter LOCK.
REQ-020 LOCK SHALL load the counter with LOCK_CYC-1 on entry and stay for exactly LOCK_CYC cycles, then enter RUN.
REQ-021 Latency: for a handshake sampled at edge T, the first cycle of PRST (pll_RESET=1, new pll_M) SHALL be T+1.
REQ-022 Latency: pll_RESET SHALL fall at T+1+RST_CYC.
REQ-023 Latency: pll_sel and pll_locked SHALL rise at T+1+RST_CYC+LOCK_CYC.
REQ-024 sleep_req=1 in RUN SHALL enter SLEEP on the next edge; pll_sel SHALL drop on the same edge that pll_asleep rises.
REQ-025 sleep_req=0 in SLEEP SHALL enter PRST with the current pll_OD/M/N (full relock).
REQ-026 sleep_req SHALL be ignored in BYPASS, PRST and LOCK, but a still-high sleep_req SHALL take effect on entry to RUN.
REQ-027 If cfg_valid and sleep_req are both high in RUN, the config SHALL win; sleep SHALL be evaluated once RUN is re-entered.
REQ-028 cfg_valid SHALL be ignored in PRST, LOCK and SLEEP (cfg_ready=0), and a request held high SHALL be accepted on return to RUN.
REQ-029 pll_OD/M/N SHALL change only on an accepted valid config or on reset; they SHALL stay stable throughout PRST, LOCK, RUN and SLEEP.
REQ-030 The counter SHALL never wrap; a count of 0 SHALL be the terminal cycle.

Reset
REQ-031 While rst=1, the block SHALL enter BYPASS on the next edge, with pll_RESET=1, pll_asleep=0, pll_sel=0, pll_locked=0, cfg_ready=1, cfg_err=0, pll_OD/M/N=DEF_OD/M/N and counter=0.
REQ-032 Reset asserted in any state, including mid-PRST, mid-LOCK and SLEEP, SHALL abort the sequence with no further output change beyond REQ-031.
REQ-033 Reset SHALL override cfg_valid and sleep_req sampled in the same cycle.

Verification (RST_CYC=4, LOCK_CYC=8)
REQ-034 Reset for 2 cycles, then idle: pll_RESET=1, pll_sel=0, cfg_ready=1, pll_M=1, pll_N=1, pll_OD=0.
REQ-035 Handshake at T with od=1, m=50, n=2: pll_M=50 at T+1; pll_RESET=1 for cycles T+1..T+4, 0 at T+5; pll_sel=pll_locked=1 at T+13.
REQ-036 Handshake in RUN with m=0: cfg_err=1 only at T+1; state stays RUN, pll_M unchanged, pll_sel stays 1.
REQ-037 In RUN, sleep_req=1 at T: at T+1 pll_asleep=1, pll_sel=0, pll_RESET=1; sleep_req=0 at T+5 -> pll_asleep=0 at T+6, pll_sel=1 at T+18.
REQ-038 rst=1 during LOCK counter=3: BYPASS next cycle; pll_RESET=1, pll_M=DEF_M, and pll_sel never rises.
REQ-039 cfg_valid and sleep_req both high in RUN: enter PRST not SLEEP; SLEEP entered at the cycle after RUN re-entry.
